regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard; successor to the fixed 8x8, 2-read/1-write register file. It sits between decode (which marks destination registers busy at issue) and writeback (which writes results and clears busy), and supplies operands plus per-operand hazard flags to the issue stage.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers (power of two, >= 2)
- NUM_RD, 2, number of read ports (>= 1)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns pre-write value
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes and marks
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_enable  in  1  writeback strobe
- write_reg  in  AW  writeback address
- write_data  in  DATA_W  writeback data
- mark_en  in  1  issue strobe: set busy for mark_reg
- mark_reg  in  AW  register being claimed by an in-flight producer
- read_reg  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
- read_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- read_busy  out  NUM_RD  port i operand not yet available
- busy  out  NUM_REGS  scoreboard vector
- busy_cnt  out  $clog2(NUM_REGS+1)  number of set busy bits
- wr_unexp  out  1  sticky: a write hit a non-busy register

## Operation
- Storage: NUM_REGS x DATA_W flops; written on rising clk when write_enable=1 (except reg 0 when ZERO_R0=1).
- Reads combinational. read_data[i] = write_data if BYPASS=1, write_enable=1, write_reg==read_reg[i] (and not zero-reg); else stored value; 0 for reg 0 when ZERO_R0=1.
- Scoreboard next state per reg r: set if mark_en && mark_reg==r; else cleared if write_enable && write_reg==r; else hold. Mark beats clear on same reg same cycle (new producer supersedes).
- busy[0] tied 0 when ZERO_R0=1; marks/writes to reg 0 then have no scoreboard effect.
- read_busy[i] = busy[read_reg[i]], except forced 0 when BYPASS=1 and the same-cycle write targets read_reg[i] (data is forwarded). Same-cycle mark on that reg does not affect read_busy this cycle.
- busy_cnt registered, equal to popcount of busy (updated with busy, same edge); never exceeds NUM_REGS.
- wr_unexp sets on edge where write_enable=1, target not zero-reg, and busy[write_reg]=0 before the edge; stays 1 until reset.

## Timing
- Reset (rst_n low, async): all registers 0, busy 0, busy_cnt 0, wr_unexp 0; read_data reflects zeros immediately. Writes/marks ignored while rst_n low; first effective edge is first rising clk after rst_n rises.
- Write latency: stored value visible on read_data the cycle after the write edge (BYPASS=0); same cycle combinationally with BYPASS=1.
- Mark latency: busy bit visible one cycle after the mark edge.
- Reset asserted mid-operation discards pending marks and write in that cycle.
- Multiple read ports reading the same address are legal and return identical values.

## Structure
- Package regfile_pkg: default constants (DATA_W, NUM_REGS, NUM_RD), popcount function.
- One sub-module regfile_rdport: per-port mux + bypass + read_busy logic, instantiated NUM_RD times via generate.
- Storage, scoreboard, busy_cnt and wr_unexp in the top.

## Test plan
- Reset: hold rst_n=0 3 cycles with write_enable=1, write_data=8'hFF -> all read_data 0, busy 0, busy_cnt 0, wr_unexp 0.
- Mark/write: mark reg 3, next cycle read_reg port0=3 -> read_busy[0]=1, busy_cnt=1; write 8'h0D to reg 3 -> after edge busy[3]=0, busy_cnt=0, read_data port0=8'h0D, wr_unexp stays 0.
- Bypass: BYPASS=1, reg 5 busy, write 8'h33 to reg 5 while both ports read 5 -> same cycle read_data both 8'h33, read_busy=2'b00; BYPASS=0 same stimulus -> old value, read_busy=2'b11.
- Simultaneous mark+write reg 2 -> busy[2]=1 after edge, data stored; busy_cnt unchanged.
- ZERO_R0=1: write 8'hAA to reg 0, mark reg 0 -> read 0 returns 0, busy[0]=0, wr_unexp=0.
- Unexpected write to non-busy reg 6 -> wr_unexp=1 next cycle, stays 1 through later legal traffic, cleared only by async reset mid-cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Register count is capped at MaxRegs so popcount can use one fixed-width argument.
package regfile_pkg;

    localparam int unsigned DefaultDataW   = 8;
    localparam int unsigned DefaultNumRegs = 8;
    localparam int unsigned DefaultNumRd   = 2;
    localparam int unsigned MaxRegs        = 256;

    function automatic int unsigned popcount(input logic [MaxRegs-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MaxRegs; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: storage mux, same-cycle write bypass and operand hazard flag.
module regfile_rdport #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_R0  = 1'b0,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]        busy,
    input  logic                       write_ok,
    input  logic [AW-1:0]              write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [AW-1:0]              read_reg,
    output logic [DATA_W-1:0]          read_data,
    output logic                       read_busy
);

    logic hit;

    always_comb begin
        hit       = BYPASS && write_ok && (write_reg == read_reg);
        read_data = regs_flat[read_reg*DATA_W +: DATA_W];
        read_busy = busy[read_reg];
        // Forwarded data is available now, so the operand is no longer a hazard.
        if (hit) begin
            read_data = write_data;
            read_busy = 1'b0;
        end
        if (ZERO_R0 && (read_reg == '0)) begin
            read_data = '0;
            read_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and per-register busy scoreboard.
// Storage, scoreboard, busy count and the sticky unexpected-write flag live here.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned NUM_REGS = DefaultNumRegs,
    parameter int unsigned NUM_RD   = DefaultNumRd,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_R0  = 1'b0,
    localparam int unsigned AW      = $clog2(NUM_REGS),
    localparam int unsigned CNT_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_enable,
    input  logic [AW-1:0]            write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     mark_en,
    input  logic [AW-1:0]            mark_reg,
    input  logic [NUM_RD*AW-1:0]     read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    output logic [NUM_REGS-1:0]      busy,
    output logic [CNT_W-1:0]         busy_cnt,
    output logic                     wr_unexp
);

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [CNT_W-1:0]           busy_cnt_q;
    logic                       wr_unexp_q;
    logic                       write_ok, mark_ok;

    // rst_n gates the bypass too, so reads show zeros while reset is held.
    assign write_ok = write_enable && rst_n && !(ZERO_R0 && (write_reg == '0));
    assign mark_ok  = mark_en && !(ZERO_R0 && (mark_reg == '0));

    // Mark is applied last: a new producer supersedes the completing one.
    always_comb begin
        busy_d = busy_q;
        if (write_ok) busy_d[write_reg] = 1'b0;
        if (mark_ok)  busy_d[mark_reg]  = 1'b1;
        if (ZERO_R0)  busy_d[0]         = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (write_ok) begin
            regs_q[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            wr_unexp_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= CNT_W'(popcount(MaxRegs'(busy_d)));
            if (write_ok && !busy_q[write_reg]) wr_unexp_q <= 1'b1;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .BYPASS   (BYPASS),
            .ZERO_R0  (ZERO_R0)
        ) u_rdport (
            .regs_flat  (regs_flat),
            .busy       (busy_q),
            .write_ok   (write_ok),
            .write_reg  (write_reg),
            .write_data (write_data),
            .read_reg   (read_reg[i*AW +: AW]),
            .read_data  (read_data[i*DATA_W +: DATA_W]),
            .read_busy  (read_busy[i])
        );
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;
    assign wr_unexp = wr_unexp_q;

endmodule
